// File: rtl/wb_pkg.sv
// Shared types, width helpers and default address map for the Wishbone interconnect.
package wb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_MASTERS    = 2;
  localparam int unsigned DEF_NUM_SLAVES     = 3;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_RESET_STRETCH  = 4;

  // Slave 0 in the low bits, slave N-1 in the high bits.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_WIDTH-1:0] DEF_SLAVE_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the grant index: clog2(NUM_MASTERS).
  function automatic int unsigned mst_idx_w(input int unsigned num_masters);
    return idx_w(num_masters);
  endfunction

  // Width of the timeout counter: clog2(TIMEOUT_CYCLES+1).
  function automatic int unsigned to_cnt_w(input int unsigned timeout_cycles);
    return idx_w(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin picker: combinational grant from last_grant+1, last_grant updated on take.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = mst_idx_w(N)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [N-1:0]     req_i,
  input  logic             take_i,
  output logic [N-1:0]     gnt_oh_c_o,
  output logic [IDX_W-1:0] gnt_idx_c_o,
  output logic             valid_c_o
);

  logic [IDX_W-1:0] last_q, last_d;

  // Search requesters starting after the last winner, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    gnt_oh_c_o  = '0;
    gnt_idx_c_o = '0;
    valid_c_o   = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= N) cand = cand - N;
      if (!valid_c_o && req_i[IDX_W'(cand)]) begin
        valid_c_o               = 1'b1;
        gnt_idx_c_o             = IDX_W'(cand);
        gnt_oh_c_o[IDX_W'(cand)] = 1'b1;
      end
    end
  end

  // Remember the winner only when the owner actually latches it.
  always_comb begin
    last_d = last_q;
    if (take_i && valid_c_o) last_d = gnt_idx_c_o;
  end

  // last_grant starts at N-1 so master 0 wins first.
  always_ff @(posedge clk_i) begin
    if (srst_i) last_q <= IDX_W'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: RR arbitration, address decode, error responder, timeout.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter  int unsigned NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter  int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter  logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int unsigned RESET_STRETCH  = DEF_RESET_STRETCH,
  localparam int unsigned SEL_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              clk_o,
  output logic                              rst_o,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
  output logic [DATA_WIDTH-1:0]             m_dat_r,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [NUM_SLAVES-1:0]             s_cyc,
  output logic [NUM_SLAVES-1:0]             s_stb,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_w,
  output logic [SEL_WIDTH-1:0]              s_sel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_r,
  input  logic [NUM_SLAVES-1:0]             s_ack,
  input  logic [NUM_SLAVES-1:0]             s_err
);

  localparam int unsigned MIDX_W = mst_idx_w(NUM_MASTERS);
  localparam int unsigned SIDX_W = idx_w(NUM_SLAVES);
  localparam int unsigned TO_W   = to_cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned RS_W   = idx_w(RESET_STRETCH + 1);

  arb_state_e              state_q, state_d;
  logic                    rst_q, rst_d;
  logic [RS_W-1:0]         rs_cnt_q, rs_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    err_q, err_d;
  logic [MIDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_MASTERS-1:0]  gnt_oh_q, gnt_oh_d;

  logic [NUM_MASTERS-1:0]  arb_oh_c;
  logic [MIDX_W-1:0]       arb_idx_c;
  logic                    arb_valid_c;
  logic                    take_c;

  logic                    cyc_g_c, stb_g_c, active_c, strobe_c;
  logic [ADDR_WIDTH-1:0]   adr_g_c;
  logic                    hit_c;
  logic [SIDX_W-1:0]       sidx_c;
  logic [NUM_SLAVES-1:0]   sel_oh_c;
  logic                    s_ack_sel_c, s_err_sel_c;
  logic                    slv_ack_c, slv_err_c, unm_err_c, to_err_c;
  logic                    ack_c, err_c;

  wb_rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_arb (
    .clk_i       (clock),
    .srst_i      (~reset),
    .req_i       (m_cyc),
    .take_i      (take_c),
    .gnt_oh_c_o  (arb_oh_c),
    .gnt_idx_c_o (arb_idx_c),
    .valid_c_o   (arb_valid_c)
  );

  // Wishbone reset stays high for RESET_STRETCH edges after release.
  always_comb begin
    rs_cnt_d = rs_cnt_q;
    rst_d    = 1'b0;
    if (rs_cnt_q != RS_W'(RESET_STRETCH)) begin
      rs_cnt_d = rs_cnt_q + RS_W'(1);
      rst_d    = 1'b1;
    end
  end

  // Arbiter next state: grant from IDLE, release when the owner drops cyc.
  always_comb begin
    state_d   = state_q;
    take_c    = 1'b0;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid_c) begin
          state_d   = ARB_OWNED;
          take_c    = 1'b1;
          gnt_idx_d = arb_idx_c;
          gnt_oh_d  = arb_oh_c;
        end
      end
      ARB_OWNED: begin
        if (!cyc_g_c) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (rst_q) begin
      state_d   = ARB_IDLE;
      take_c    = 1'b0;
      gnt_idx_d = gnt_idx_q;
      gnt_oh_d  = gnt_oh_q;
    end
  end

  // Granted master's bus signals.
  always_comb begin
    cyc_g_c  = m_cyc[gnt_idx_q];
    stb_g_c  = m_stb[gnt_idx_q];
    adr_g_c  = m_adr[gnt_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
    active_c = (state_q == ARB_OWNED) && cyc_g_c;
    strobe_c = active_c && stb_g_c;
  end

  // Address decode, lowest matching slave index wins.
  always_comb begin
    hit_c    = 1'b0;
    sidx_c   = '0;
    sel_oh_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_c &&
          ((adr_g_c & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_c       = 1'b1;
        sidx_c      = SIDX_W'(i);
        sel_oh_c[i] = 1'b1;
      end
    end
  end

  // Response merge: slave err beats ack; unmapped and timeout errors are internal.
  always_comb begin
    s_ack_sel_c = s_ack[sidx_c];
    s_err_sel_c = s_err[sidx_c];
    slv_err_c   = strobe_c && hit_c && s_err_sel_c;
    slv_ack_c   = strobe_c && hit_c && s_ack_sel_c && !s_err_sel_c;
    unm_err_c   = active_c && err_q;
    to_err_c    = strobe_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) &&
                  !(hit_c && (s_ack_sel_c || s_err_sel_c));
    err_c       = slv_err_c || unm_err_c || to_err_c;
    ack_c       = slv_ack_c && !err_c;
    err_d       = strobe_c && !hit_c && !err_q;
    to_cnt_d    = (strobe_c && !ack_c && !err_c) ? to_cnt_q + TO_W'(1) : '0;
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rst_q     <= 1'b1;
      rs_cnt_q  <= '0;
      state_q   <= ARB_IDLE;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rst_q     <= rst_d;
      rs_cnt_q  <= rs_cnt_d;
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  assign clk_o   = clock;
  assign rst_o   = rst_q;
  assign s_cyc   = {NUM_SLAVES{active_c}} & sel_oh_c;
  assign s_stb   = {NUM_SLAVES{strobe_c}} & sel_oh_c;
  assign s_we    = m_we[gnt_idx_q];
  assign s_adr   = adr_g_c;
  assign s_dat_w = m_dat_w[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign s_sel   = m_sel[gnt_idx_q*SEL_WIDTH +: SEL_WIDTH];
  assign m_ack   = {NUM_MASTERS{ack_c}} & gnt_oh_q;
  assign m_err   = {NUM_MASTERS{err_c}} & gnt_oh_q;
  assign m_dat_r = (active_c && hit_c) ? s_dat_r[sidx_c*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed and randomized checks of wb_interconnect against a transaction-level model.
module tb_wb_interconnect;

  localparam logic [31:0] BASE_TBL [3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK       = 32'hF000_0000;

  logic        clock;
  logic        reset;
  logic        clk_o, rst_o;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat_w;
  logic [7:0]  m_sel;
  logic [31:0] m_dat_r;
  logic [1:0]  m_ack, m_err;
  logic [2:0]  s_cyc, s_stb;
  logic        s_we;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic [95:0] s_dat_r;
  logic [2:0]  s_ack, s_err;

  int checks = 0;
  int errors = 0;

  wb_interconnect dut (
    .clock   (clock),
    .reset   (reset),
    .clk_o   (clk_o),
    .rst_o   (rst_o),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_dat_r (m_dat_r),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_dat_r (s_dat_r),
    .s_ack   (s_ack),
    .s_err   (s_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: which slave owns an address (-1 = unmapped), lowest index first.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & MASK) == BASE_TBL[i]) return i;
    return -1;
  endfunction

  // Model: round-robin winner among requesters, searching after the last winner.
  function automatic int rr_pick(input int last, input logic [1:0] req);
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (last + k) % 2;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  int          last_g, g, sl, d, resp;
  logic [1:0]  req;
  logic [31:0] adr_m [2];
  logic [95:0] dat_tmp;
  logic [2:0]  sel_bit, noise;
  logic [1:0]  g_bit;

  initial begin
    reset   = 1'b0;
    m_cyc   = '0; m_stb = '0; m_we = '0;
    m_adr   = '0; m_dat_w = '0; m_sel = '0;
    s_dat_r = '0; s_ack = '0; s_err = '0;

    // Reset held low for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_o_in_reset", rst_o, 1);
      chk("m_ack_in_reset", m_ack, 0);
      chk("m_err_in_reset", m_err, 0);
      chk("s_cyc_in_reset", s_cyc, 0);
    end
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("rst_o_stretch_e%0d", e), rst_o, (e <= 4) ? 1 : 0);
    end

    // Both masters request together: master 0 first; slave 1 acks a read in the same cycle.
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = {32'h2000_0000, 32'h1000_0010};
    s_dat_r[63:32] = 32'hDEAD_BEEF;
    s_ack = 3'b010;
    #1;
    chk("idle_no_scyc", s_cyc, 0);
    chk("idle_no_ack", m_ack, 0);
    step();
    chk("m0_s_cyc", s_cyc, 3'b010);
    chk("m0_s_stb", s_stb, 3'b010);
    chk("m0_ack", m_ack, 2'b01);
    chk("m0_dat_r", m_dat_r, 32'hDEAD_BEEF);
    chk("m0_s_adr", s_adr, 32'h1000_0010);
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("drop_s_cyc", s_cyc, 0);
    chk("late_ack_blocked", m_ack, 0);
    step();
    s_ack = '0;
    #1;
    chk("dead_cycle", s_cyc, 0);
    step();
    chk("m1_granted", s_cyc, 3'b100);
    step();
    m_cyc = '0; m_stb = '0;
    #1;
    chk("m1_drop", s_cyc, 0);

    // Unmapped strobe from master 1: error one cycle later, no slave cycle.
    step();
    m_cyc = 2'b10; m_stb = 2'b10;
    m_adr[63:32] = 32'h5000_0000;
    #1;
    step();
    chk("unm_s_cyc_b", s_cyc, 0);
    chk("unm_err_b", m_err, 0);
    step();
    chk("unm_s_cyc_b1", s_cyc, 0);
    chk("unm_err_b1", m_err, 2'b10);
    chk("unm_dat_r", m_dat_r, 0);
    step();
    m_cyc = '0; m_stb = '0;
    #1;
    chk("unm_drop_err", m_err, 0);

    // Slave 2 never answers: error every 256th strobe cycle.
    step();
    m_cyc = 2'b01; m_stb = 2'b01;
    m_adr[31:0] = 32'h2000_0040;
    #1;
    for (int k = 1; k <= 520; k++) begin
      step();
      chk($sformatf("timeout_k%0d", k), m_err, (k % 256 == 0) ? 2'b01 : 2'b00);
    end
    step();
    m_cyc = '0; m_stb = '0;
    #1;

    // Reset while slave 1 is about to ack: transfer aborted, no ack leaks.
    step();
    m_cyc = 2'b01; m_stb = 2'b01;
    m_adr[31:0] = 32'h1000_0000;
    #1;
    step();
    chk("pre_reset_grant", s_cyc, 3'b010);
    step();
    reset = 1'b0;
    #1;
    chk("pre_reset_no_ack", m_ack, 0);
    step();
    reset = 1'b1;
    s_ack = 3'b010;
    #1;
    chk("abort_ack", m_ack, 0);
    chk("abort_s_cyc", s_cyc, 0);
    chk("abort_rst_o", rst_o, 1);
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e == 4) begin
        m_cyc = '0; m_stb = '0; s_ack = '0;
      end
      #1;
      chk($sformatf("abort_ack_e%0d", e), m_ack, 0);
      chk($sformatf("abort_scyc_e%0d", e), s_cyc, 0);
      chk($sformatf("abort_rst_e%0d", e), rst_o, 1);
    end
    step();
    chk("post_abort_rst_o", rst_o, 0);

    // Randomized transactions against the model; last_grant restarts at master 1.
    last_g = 1;
    for (int t = 0; t < 60; t++) begin
      req = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) == 3)
          adr_m[m] = (32'($urandom_range(3, 15)) << 28) | ($urandom & 32'h0FFF_FFFF);
        else
          adr_m[m] = BASE_TBL[$urandom_range(0, 2)] | ($urandom & 32'h0FFF_FFFF);
      end
      g      = rr_pick(last_g, req);
      last_g = g;
      sl     = decode(adr_m[g]);
      g_bit  = 2'b01 << g;
      sel_bit = (sl >= 0) ? (3'b001 << sl) : 3'b000;

      step();
      m_cyc = req; m_stb = req;
      m_adr = {adr_m[1], adr_m[0]};
      m_we  = 2'($urandom);
      s_dat_r = {$urandom, $urandom, $urandom};
      s_ack = '0; s_err = '0;
      #1;
      chk($sformatf("r%0d_idle_scyc", t), s_cyc, 0);
      chk($sformatf("r%0d_idle_ack", t), m_ack, 0);

      if (sl < 0) begin
        step();
        chk($sformatf("r%0d_unm_scyc", t), s_cyc, 0);
        chk($sformatf("r%0d_unm_err0", t), m_err, 0);
        chk($sformatf("r%0d_unm_dat", t), m_dat_r, 0);
        step();
        chk($sformatf("r%0d_unm_err1", t), m_err, g_bit);
        chk($sformatf("r%0d_unm_ack1", t), m_ack, 0);
      end else begin
        d    = $urandom_range(0, 2);
        resp = $urandom_range(0, 2);
        for (int c = 0; c <= d; c++) begin
          step();
          noise = 3'($urandom_range(0, 7)) & ~sel_bit;
          s_ack = noise;
          s_err = 3'($urandom_range(0, 7)) & ~sel_bit;
          if (c == d) begin
            if (resp != 1) s_ack = s_ack | sel_bit;
            if (resp != 0) s_err = s_err | sel_bit;
          end
          #1;
          dat_tmp = s_dat_r;
          chk($sformatf("r%0d_c%0d_scyc", t, c), s_cyc, sel_bit);
          chk($sformatf("r%0d_c%0d_sadr", t, c), s_adr, adr_m[g]);
          chk($sformatf("r%0d_c%0d_dat", t, c), m_dat_r, dat_tmp[sl*32 +: 32]);
          chk($sformatf("r%0d_c%0d_ack", t, c), m_ack, (c == d && resp == 0) ? g_bit : 2'b00);
          chk($sformatf("r%0d_c%0d_err", t, c), m_err, (c == d && resp != 0) ? g_bit : 2'b00);
        end
      end

      step();
      m_cyc = '0; m_stb = '0;
      s_ack = 3'($urandom_range(0, 7)); s_err = '0;
      #1;
      chk($sformatf("r%0d_drop_scyc", t), s_cyc, 0);
      chk($sformatf("r%0d_drop_ack", t), m_ack, 0);
      chk($sformatf("r%0d_drop_err", t), m_err, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of Wishbone masters (1..8).
REQ-002 Parameter NUM_SLAVES, default 3, number of Wishbone slaves (1..8).
REQ-003 Parameter ADDR_WIDTH, default 32, address width.
REQ-004 Parameter DATA_WIDTH, default 32, data width; SEL_WIDTH = DATA_WIDTH/8.
REQ-005 Parameter SLAVE_BASE[NUM_SLAVES], default {0x0000_0000, 0x1000_0000, 0x2000_0000}, per-slave base address.
REQ-006 Parameter SLAVE_MASK[NUM_SLAVES], default {0xF000_0000 each}, per-slave decode mask.
REQ-007 Parameter TIMEOUT_CYCLES, default 255, strobe cycles before forced error.
REQ-008 Parameter RESET_STRETCH, default 4, rst_o extension cycles after reset release.
REQ-009 clock  in  1  system clock; the single clock for the block and for all buses.
REQ-010 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-011 clk_o  out  1  clock distributed to every master and slave (equals clock).
REQ-012 rst_o  out  1  active-high Wishbone reset distributed to every master and slave.
REQ-013 m_cyc, m_stb, m_we  in  NUM_MASTERS each  per-master cycle, strobe and write.
REQ-014 m_adr  in  NUM_MASTERS*ADDR_WIDTH  per-master address.
REQ-015 m_dat_w  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
REQ-016 m_sel  in  NUM_MASTERS*SEL_WIDTH  per-master byte select.
REQ-017 m_dat_r  out  DATA_WIDTH  shared read data, broadcast to all masters.
REQ-018 m_ack, m_err  out  NUM_MASTERS each  per-master acknowledge and error.
REQ-019 s_cyc, s_stb  out  NUM_SLAVES each  per-slave cycle and strobe.
REQ-020 s_we, s_adr, s_dat_w, s_sel  out  1/ADDR_WIDTH/DATA_WIDTH/SEL_WIDTH  shared, driven from the granted master.
REQ-021 s_dat_r  in  NUM_SLAVES*DATA_WIDTH  per-slave read data.
REQ-022 s_ack, s_err  in  NUM_SLAVES each  per-slave acknowledge and error.

Function
REQ-023 rst_o is 1 while reset=0 and for exactly RESET_STRETCH clock edges after the first edge sampling reset=1.
REQ-024 The arbiter FSM has states IDLE and OWNED; while rst_o=1 it is forced to IDLE.
REQ-025 IDLE -> OWNED on the first edge with any m_cyc=1; the grant is registered, so it is visible one cycle after the request.
REQ-026 The grant goes round-robin: search starts at last_grant+1 and wraps modulo NUM_MASTERS.
REQ-027 OWNED holds the grant while the granted m_cyc=1; when it drops, the FSM returns to IDLE with one dead cycle before the next grant.
REQ-028 Slave i is selected when (granted adr & SLAVE_MASK[i]) == SLAVE_BASE[i]; if regions overlap, the lowest index wins; decode is combinational.
REQ-029 s_cyc[i] and s_stb[i] equal the granted m_cyc/m_stb ANDed with select[i]; all other slaves see 0.
REQ-030 The granted master's m_ack and m_err follow the selected slave combinationally (zero added latency); m_dat_r is s_dat_r of the selected slave, otherwise 0.
REQ-031 Non-granted masters see m_ack=0 and m_err=0 at all times.
REQ-032 If s_ack and s_err are both 1, m_err=1 and m_ack=0.
REQ-033 Unmapped address with stb=1: the internal responder asserts m_err one cycle later for one cycle per strobe; no s_cyc is raised.
REQ-034 Timeout: a counter clears on ack, on err, and on stb=0.
  - When the counter reaches TIMEOUT_CYCLES with stb still high, m_err is asserted for one cycle and the counter clears.
REQ-035 If the master drops m_cyc mid-transfer, s_cyc/s_stb drop in the same cycle, and a late slave ack is not forwarded.

Reset
REQ-036 reset is sampled only on the rising edge of clock (synchronous, active-low).
REQ-037 Reset values:
  - FSM = IDLE; last_grant = NUM_MASTERS-1, so master 0 wins first.
  - Timeout counter, stretch counter and error-responder flag = 0.
  - rst_o = 1; all m_ack, m_err, s_cyc, s_stb = 0.
REQ-038 Reset mid-transfer aborts the transfer in the cycle reset is sampled; no ack or err is forwarded afterwards.

Structure
REQ-039 Shared package wb_pkg holds:
  - the arbiter state enum;
  - the widths clog2(NUM_MASTERS) and clog2(TIMEOUT_CYCLES+1);
  - the default base/mask constants.
REQ-040 One sub-module, wb_rr_arbiter (request vector in, one-hot grant and index out, last_grant register), is instantiated once.

Verification
REQ-041 reset=0 for 3 cycles then 1, RESET_STRETCH=4 -> rst_o=1 through the 4th edge after release, then 0.
REQ-042 Both masters raise cyc in the same cycle after reset -> master 0 granted first; after it drops cyc and one dead cycle, master 1 is granted.
REQ-043 Master 0 reads 0x1000_0010 and slave 1 acks with data 0xDEADBEEF -> s_cyc=3'b010, and m_ack[0]=1 with m_dat_r=0xDEADBEEF in the same cycle.
REQ-044 Master 1 strobes 0x5000_0000 (unmapped) -> m_err[1]=1 exactly one cycle later; all s_cyc stay 0.
REQ-045 Slave 2 never acks, TIMEOUT_CYCLES=255 -> m_err pulses once after 255 strobe cycles; the counter restarts if stb stays high.
REQ-046 reset=0 asserted while slave ack is pending -> FSM returns to IDLE, and no m_ack reaches the master.
